axi_lite_mem_ctrl: RTL and testbench

- AXI4-Lite slave controller that sequences the single-port-per-direction register-file `memory` block (addr_width/data_width/depth parameters; w_en, out_en, write_address, read_address, write_data, read_data).
- Accepts independent AW/W/AR requests, arbitrates read vs. write access round-robin, and drives the memory control strobes.
- Returns B/R responses, including SLVERR for illegal accesses.
- Sits between the AXI4-Lite interconnect and `memory`.

---
 rtl/axi_lite_mem_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_axi_lite_mem_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_mem_ctrl.sv
// rtl/axi_lite_mem_ctrl.sv - AXI4-Lite slave that sequences a single-port-per-direction register-file memory
//
// Ports:
//   clk, reset           : single clock, synchronous active-high reset
//   s_aw*/s_w*/s_b*      : AXI4-Lite write address, write data and write response channels
//   s_ar*/s_r*           : AXI4-Lite read address and read data channels
//   mem_*                : control, address and data to/from the memory (read data one cycle after mem_out_en)
module axi_lite_mem_ctrl #(
    parameter int ADDR_WIDTH     = 5,
    parameter int DATA_WIDTH     = 32,
    parameter int DEPTH          = 32,
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_awaddr,
    input  logic                        s_awvalid,
    output logic                        s_awready,
    input  logic [DATA_WIDTH-1:0]       s_wdata,
    input  logic [DATA_WIDTH/8-1:0]     s_wstrb,
    input  logic                        s_wvalid,
    output logic                        s_wready,
    output logic [1:0]                  s_bresp,
    output logic                        s_bvalid,
    input  logic                        s_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_araddr,
    input  logic                        s_arvalid,
    output logic                        s_arready,
    output logic [DATA_WIDTH-1:0]       s_rdata,
    output logic [1:0]                  s_rresp,
    output logic                        s_rvalid,
    input  logic                        s_rready,
    output logic [ADDR_WIDTH-1:0]       mem_write_address,
    output logic [ADDR_WIDTH-1:0]       mem_read_address,
    output logic [DATA_WIDTH-1:0]       mem_write_data,
    output logic                        mem_w_en,
    output logic                        mem_out_en,
    input  logic [DATA_WIDTH-1:0]       mem_read_data
);

    localparam logic [AXI_ADDR_WIDTH-1:0] ADDR_LIMIT = AXI_ADDR_WIDTH'(DEPTH * 4);

    typedef enum logic [2:0] {S_IDLE, S_WR, S_BRESP, S_RD, S_RWAIT, S_RRESP} state_t;

    state_t                  state_q, state_d;
    logic                    aw_full_q, aw_full_d, w_full_q, w_full_d, ar_full_q, ar_full_d;
    logic                    aw_err_q, aw_err_d, w_err_q, w_err_d, ar_err_q, ar_err_d;
    logic [ADDR_WIDTH-1:0]   aw_word_q, aw_word_d, ar_word_q, ar_word_d;
    logic [DATA_WIDTH-1:0]   w_data_q, w_data_d;
    logic                    awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic                    bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]              bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    w_en_q, w_en_d, out_en_q, out_en_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d, raddr_q, raddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    prio_wr_q, prio_wr_d;   // 1: write wins the next tie

    logic wr_pend, rd_pend;

    always_comb begin
        state_d   = state_q;
        aw_full_d = aw_full_q;
        w_full_d  = w_full_q;
        ar_full_d = ar_full_q;
        aw_err_d  = aw_err_q;
        w_err_d   = w_err_q;
        ar_err_d  = ar_err_q;
        aw_word_d = aw_word_q;
        ar_word_d = ar_word_q;
        w_data_d  = w_data_q;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        bresp_d   = bresp_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        w_en_d    = 1'b0;
        out_en_d  = 1'b0;
        waddr_d   = waddr_q;
        raddr_d   = raddr_q;
        wdata_d   = wdata_q;
        prio_wr_d = prio_wr_q;
        wr_pend   = aw_full_q && w_full_q;
        rd_pend   = ar_full_q;

        // Slot loads; the error decision travels with the captured request.
        if (s_awvalid && awready_q) begin
            aw_full_d = 1'b1;
            aw_word_d = s_awaddr[ADDR_WIDTH+1:2];
            aw_err_d  = (s_awaddr >= ADDR_LIMIT);
        end
        if (s_wvalid && wready_q) begin
            w_full_d = 1'b1;
            w_data_d = s_wdata;
            w_err_d  = !(&s_wstrb);
        end
        if (s_arvalid && arready_q) begin
            ar_full_d = 1'b1;
            ar_word_d = s_araddr[ADDR_WIDTH+1:2];
            ar_err_d  = (s_araddr >= ADDR_LIMIT);
        end

        case (state_q)
            S_IDLE: begin
                if (wr_pend && (!rd_pend || prio_wr_q)) begin
                    state_d   = S_WR;
                    w_en_d    = !(aw_err_q || w_err_q);
                    waddr_d   = aw_word_q;
                    wdata_d   = w_data_q;
                    prio_wr_d = 1'b0;
                end else if (rd_pend) begin
                    state_d   = S_RD;
                    out_en_d  = !ar_err_q;
                    raddr_d   = ar_word_q;
                    prio_wr_d = 1'b1;
                end
            end
            S_WR: begin
                state_d  = S_BRESP;
                bvalid_d = 1'b1;
                bresp_d  = (aw_err_q || w_err_q) ? 2'b10 : 2'b00;
            end
            S_BRESP: begin
                if (s_bready) begin
                    state_d   = S_IDLE;
                    bvalid_d  = 1'b0;
                    aw_full_d = 1'b0;
                    w_full_d  = 1'b0;
                end
            end
            S_RD: state_d = S_RWAIT;
            S_RWAIT: begin
                // Memory data is valid this cycle because out_en was sampled last cycle.
                state_d  = S_RRESP;
                rvalid_d = 1'b1;
                rdata_d  = ar_err_q ? '0 : mem_read_data;
                rresp_d  = ar_err_q ? 2'b10 : 2'b00;
            end
            S_RRESP: begin
                if (s_rready) begin
                    state_d   = S_IDLE;
                    rvalid_d  = 1'b0;
                    ar_full_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Readies are registered copies of next-cycle slot emptiness.
        awready_d = !aw_full_d;
        wready_d  = !w_full_d;
        arready_d = !ar_full_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            aw_full_q <= 1'b0;
            w_full_q  <= 1'b0;
            ar_full_q <= 1'b0;
            aw_err_q  <= 1'b0;
            w_err_q   <= 1'b0;
            ar_err_q  <= 1'b0;
            aw_word_q <= '0;
            ar_word_q <= '0;
            w_data_q  <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rresp_q   <= 2'b00;
            rdata_q   <= '0;
            w_en_q    <= 1'b0;
            out_en_q  <= 1'b0;
            waddr_q   <= '0;
            raddr_q   <= '0;
            wdata_q   <= '0;
            prio_wr_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            aw_full_q <= aw_full_d;
            w_full_q  <= w_full_d;
            ar_full_q <= ar_full_d;
            aw_err_q  <= aw_err_d;
            w_err_q   <= w_err_d;
            ar_err_q  <= ar_err_d;
            aw_word_q <= aw_word_d;
            ar_word_q <= ar_word_d;
            w_data_q  <= w_data_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            arready_q <= arready_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            bresp_q   <= bresp_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            w_en_q    <= w_en_d;
            out_en_q  <= out_en_d;
            waddr_q   <= waddr_d;
            raddr_q   <= raddr_d;
            wdata_q   <= wdata_d;
            prio_wr_q <= prio_wr_d;
        end
    end

    assign s_awready         = awready_q;
    assign s_wready          = wready_q;
    assign s_arready         = arready_q;
    assign s_bvalid          = bvalid_q;
    assign s_bresp           = bresp_q;
    assign s_rvalid          = rvalid_q;
    assign s_rresp           = rresp_q;
    assign s_rdata           = rdata_q;
    assign mem_w_en          = w_en_q;
    assign mem_out_en        = out_en_q;
    assign mem_write_address = waddr_q;
    assign mem_read_address  = raddr_q;
    assign mem_write_data    = wdata_q;

endmodule

// File: tb/tb_axi_lite_mem_ctrl.sv
// tb/tb_axi_lite_mem_ctrl.sv - self-checking bench for axi_lite_mem_ctrl
module tb_axi_lite_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [3:0]  s_wstrb;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [1:0]  s_bresp, s_rresp;
    logic [4:0]  mem_write_address, mem_read_address;
    logic [31:0] mem_write_data, mem_read_data;
    logic        mem_w_en, mem_out_en;

    axi_lite_mem_ctrl #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .DEPTH(32), .AXI_ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .mem_write_address(mem_write_address), .mem_read_address(mem_read_address),
        .mem_write_data(mem_write_data), .mem_w_en(mem_w_en), .mem_out_en(mem_out_en),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Register-file memory model driven by the DUT strobes.
    logic [31:0] mem_arr [32];
    always @(posedge clk) begin
        if (mem_w_en) mem_arr[mem_write_address] <= mem_write_data;
        if (mem_out_en) mem_read_data <= mem_arr[mem_read_address];
    end

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } rexp_t;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    logic [1:0] bq[$];
    rexp_t      rq[$];
    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int wen_cnt = 0, oen_cnt = 0, wen_cyc = 0, oen_cyc = 0, bv_cyc = 0, rv_cyc = 0, bhs_cyc = 0;
    int wr_hs_cyc = 0, ar_hs_cyc = 0;
    logic [4:0] wen_addr = '0, oen_addr = '0;
    logic bv_prev = 1'b0, rv_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Observes strobes and pops the scoreboard on every B/R handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_w_en || mem_out_en) check("wen_oen_exclusive", 64'(mem_w_en && mem_out_en), 64'd0);
            if (mem_w_en) begin
                wen_cnt <= wen_cnt + 1; wen_cyc <= cyc; wen_addr <= mem_write_address;
            end
            if (mem_out_en) begin
                oen_cnt <= oen_cnt + 1; oen_cyc <= cyc; oen_addr <= mem_read_address;
            end
            if (s_bvalid && !bv_prev) bv_cyc <= cyc;
            if (s_rvalid && !rv_prev) rv_cyc <= cyc;
            if (s_bvalid && s_bready) begin
                bhs_cyc <= cyc;
                if (bq.size() == 0) check("unexpected_b", 64'd1, 64'd0);
                else begin
                    check("bresp", 64'(s_bresp), 64'(bq[0]));
                    bq.delete(0);
                end
            end
            if (s_rvalid && s_rready) begin
                if (rq.size() == 0) check("unexpected_r", 64'd1, 64'd0);
                else begin
                    check("rresp", 64'(s_rresp), 64'(rq[0].resp));
                    check("rdata", 64'(s_rdata), 64'(rq[0].data));
                    rq.delete(0);
                end
            end
        end
        bv_prev <= s_bvalid;
        rv_prev <= s_rvalid;
    end

    task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input logic [1:0] resp, input int aw_delay);
        int start_wen;
        bit aw_got, w_got, aw_d, w_d;
        bq.push_back(resp);
        @(posedge clk); #1;
        start_wen = wen_cnt;
        s_awaddr = addr; s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1;
        aw_got = 1'b0; w_got = 1'b0;
        for (int i = 0; i < 100 && !(aw_got && w_got); i++) begin
            if (i >= aw_delay && !aw_got) s_awvalid = 1'b1;
            @(negedge clk);
            aw_d = s_awvalid && s_awready;
            w_d  = s_wvalid && s_wready;
            if (aw_d) aw_got = 1'b1;
            if (w_d) w_got = 1'b1;
            if (aw_got && w_got) wr_hs_cyc = cyc;
            if (aw_d && aw_delay > 0) check("w_first_no_wen", 64'(wen_cnt - start_wen), 64'd0);
            @(posedge clk); #1;
            if (aw_d) s_awvalid = 1'b0;
            if (w_d) s_wvalid = 1'b0;
        end
        check("wr_accept", 64'({aw_got, w_got}), 64'd3);
        s_awvalid = 1'b0; s_wvalid = 1'b0;
    endtask

    task automatic read_txn(input logic [31:0] addr, input logic [1:0] resp, input logic [31:0] data);
        bit got;
        rq.push_back(rexp_t'{resp, data});
        @(posedge clk); #1;
        s_araddr = addr; s_arvalid = 1'b1; got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            if (s_arready) begin got = 1'b1; ar_hs_cyc = cyc; end
            @(posedge clk); #1;
        end
        s_arvalid = 1'b0;
        check("rd_accept", 64'(got), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && (bq.size() != 0 || rq.size() != 0); i++) @(negedge clk);
        check("drain", 64'(bq.size() + rq.size()), 64'd0);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    vec_t vecs[10];
    int w0, o0;
    logic [1:0] bresp_hold;

    initial begin
        vecs[0] = '{1'b1, 32'h04,  32'h1111_1111, 4'hF, 2'b00, 32'h0};
        vecs[1] = '{1'b1, 32'h80,  32'h2222_2222, 4'hF, 2'b10, 32'h0};
        vecs[2] = '{1'b1, 32'h04,  32'h3333_3333, 4'h3, 2'b10, 32'h0};
        vecs[3] = '{1'b0, 32'h04,  32'h0,         4'h0, 2'b00, 32'h1111_1111};
        vecs[4] = '{1'b0, 32'h100, 32'h0,         4'h0, 2'b10, 32'h0};
        vecs[5] = '{1'b0, 32'h05,  32'h0,         4'h0, 2'b00, 32'h1111_1111};
        vecs[6] = '{1'b1, 32'h00,  32'hCAFE_F00D, 4'hF, 2'b00, 32'h0};
        vecs[7] = '{1'b0, 32'h03,  32'h0,         4'h0, 2'b00, 32'hCAFE_F00D};
        vecs[8] = '{1'b0, 32'h80,  32'h0,         4'h0, 2'b10, 32'h0};
        vecs[9] = '{1'b1, 32'h7F,  32'h4444_4444, 4'hE, 2'b10, 32'h0};

        reset = 1'b1;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_araddr = '0; s_arvalid = 1'b0; s_bready = 1'b1; s_rready = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", 64'({s_awready, s_wready, s_arready, s_bvalid, s_bresp, s_rvalid, s_rresp,
                                 mem_w_en, mem_out_en, mem_write_address, mem_read_address}), 64'd0);
        check("reset_rdata", 64'(s_rdata), 64'd0);
        check("reset_mem_wdata", 64'(mem_write_data), 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ready_after_reset", 64'({s_awready, s_wready, s_arready}), 64'd7);

        // Write then read with exact latencies.
        w0 = wen_cnt; o0 = oen_cnt;
        write_txn(32'h08, 32'hDEAD_BEEF, 4'hF, 2'b00, 0);
        drain();
        check("wr_wen_latency", 64'(wen_cyc - wr_hs_cyc), 64'd2);
        check("wr_bvalid_latency", 64'(bv_cyc - wr_hs_cyc), 64'd3);
        check("wr_word_addr", 64'(wen_addr), 64'd2);
        check("wr_wen_pulses", 64'(wen_cnt - w0), 64'd1);
        read_txn(32'h08, 2'b00, 32'hDEAD_BEEF);
        drain();
        check("rd_oen_latency", 64'(oen_cyc - ar_hs_cyc), 64'd2);
        check("rd_rvalid_latency", 64'(rv_cyc - ar_hs_cyc), 64'd4);
        check("rd_word_addr", 64'(oen_addr), 64'd2);
        check("rd_oen_pulses", 64'(oen_cnt - o0), 64'd1);

        // W two cycles ahead of AW.
        write_txn(32'h7C, 32'hA5A5_A5A5, 4'hF, 2'b00, 2);
        drain();
        check("w_first_word_addr", 64'(wen_addr), 64'd31);
        read_txn(32'h7C, 2'b00, 32'hA5A5_A5A5);
        drain();

        // Table vectors: decode, errors, strobe rules.
        for (int k = 0; k < 10; k++) begin
            w0 = wen_cnt; o0 = oen_cnt;
            if (vecs[k].wr) write_txn(vecs[k].addr, vecs[k].data, vecs[k].strb, vecs[k].resp, 0);
            else read_txn(vecs[k].addr, vecs[k].resp, vecs[k].rdata);
            drain();
            if (vecs[k].wr) check($sformatf("vec%0d_wen_count", k), 64'(wen_cnt - w0), 64'(vecs[k].resp == 2'b00));
            else check($sformatf("vec%0d_oen_count", k), 64'(oen_cnt - o0), 64'(vecs[k].resp == 2'b00));
        end

        // Simultaneous requests and round-robin arbitration.
        apply_reset();
        fork
            write_txn(32'h10, 32'h1, 4'hF, 2'b00, 0);
            read_txn(32'h10, 2'b00, 32'h1);
        join
        drain();
        check("tie_write_first", 64'(oen_cyc > wen_cyc), 64'd1);
        write_txn(32'h10, 32'h2, 4'hF, 2'b00, 0);
        drain();
        fork
            write_txn(32'h10, 32'h3, 4'hF, 2'b00, 0);
            read_txn(32'h10, 2'b00, 32'h2);
        join
        drain();
        check("tie_read_first", 64'(oen_cyc < wen_cyc), 64'd1);
        read_txn(32'h10, 2'b00, 32'h3);
        drain();

        // B backpressure with an AR accepted during the hold.
        s_bready = 1'b0;
        write_txn(32'h0C, 32'h1234_5678, 4'hF, 2'b00, 0);
        read_txn(32'h08, 2'b00, 32'hDEAD_BEEF);
        o0 = oen_cnt;
        for (int i = 0; i < 50 && !s_bvalid; i++) @(negedge clk);
        check("bvalid_seen", 64'(s_bvalid), 64'd1);
        bresp_hold = s_bresp;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("b_hold_valid", 64'(s_bvalid), 64'd1);
            check("b_hold_resp", 64'(s_bresp), 64'(bresp_hold));
            check("b_hold_awready", 64'({s_awready, s_wready, s_arready}), 64'd0);
            check("b_hold_no_read", 64'(oen_cnt - o0), 64'd0);
        end
        @(posedge clk); #1 s_bready = 1'b1;
        drain();
        check("ar_after_b", 64'(oen_cyc > bhs_cyc), 64'd1);

        // R backpressure.
        s_rready = 1'b0;
        read_txn(32'h0C, 2'b00, 32'h1234_5678);
        for (int i = 0; i < 50 && !s_rvalid; i++) @(negedge clk);
        check("rvalid_seen", 64'(s_rvalid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("r_hold_valid", 64'(s_rvalid), 64'd1);
            check("r_hold_data", 64'(s_rdata), 64'h1234_5678);
            check("r_hold_resp", 64'(s_rresp), 64'd0);
        end
        @(posedge clk); #1 s_rready = 1'b1;
        drain();

        // Reset while RVALID is held.
        s_rready = 1'b0;
        read_txn(32'h10, 2'b00, 32'h3);
        for (int i = 0; i < 50 && !s_rvalid; i++) @(negedge clk);
        check("rvalid_before_reset", 64'(s_rvalid), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        rq.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        s_rready = 1'b1;
        @(negedge clk);
        check("reset_mid_rvalid", 64'({s_rvalid, s_bvalid, mem_w_en, mem_out_en}), 64'd0);
        check("reset_mid_readies", 64'({s_awready, s_wready, s_arready}), 64'd0);
        @(negedge clk);
        check("release_readies", 64'({s_awready, s_wready, s_arready}), 64'd7);
        read_txn(32'h08, 2'b00, 32'hDEAD_BEEF);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
